// File: rtl/pipe_buffer.sv
// Valid-tagged delay line with bubble-collapsing back-pressure, synchronous flush
// and a registered occupancy counter, used to align GRNG datapath stages.
module pipe_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] v_reg;
  logic [WIDTH-1:0] d_reg [DEPTH];
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [CNT_W-1:0] occ_reg;
  logic             in_fire;
  logic             out_fire;

  // A stage loads when empty or when the stage ahead of it frees up this cycle;
  // this walks from the output back to stage 0, so in_ready depends on out_ready.
  always_comb begin
    ld = '0;
    ld[DEPTH-1] = ~v_reg[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      ld[i] = ~v_reg[i] | ld[i+1];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
    if (gi == 0) begin : g_head
      assign src_v[gi] = in_valid;
      assign src_d[gi] = in_data;
    end else begin : g_link
      assign src_v[gi] = v_reg[gi-1];
      assign src_d[gi] = d_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          v_reg[i] <= 1'b0;
        end else if (ld[i]) begin
          v_reg[i] <= src_v[i];
        end
        // Data only follows a valid source so empty slots keep their old contents.
        if (ld[i] && src_v[i]) begin
          d_reg[i] <= src_d[i];
        end
      end
    end
  end

  assign in_ready  = ld[0] & ~flush & ~rst;
  assign out_valid = v_reg[DEPTH-1];
  assign out_data  = d_reg[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_reg <= '0;
    end else if (in_fire && !out_fire) begin
      occ_reg <= occ_reg + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      occ_reg <= occ_reg - CNT_W'(1);
    end
  end

  assign occupancy = occ_reg;

endmodule

// File: doc/pipe_buffer.md
Name: pipe_buffer

Overview:
- Parametrised, valid/ready-tagged delay line for aligning GRNG datapath stages of differing latency; successor of the single-register buffer.
- Adds configurable depth, per-stage valid tags, bubble-collapsing back-pressure, synchronous flush and an occupancy count.
- Data is passed bit-exact (signed values are carried unchanged).
- Sits between GRNG core stages, e.g. delaying uniform samples to meet the Box-Muller/CLT outputs.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1); latency in cycles with no stalls.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stages; data contents are not required to clear.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage 0 accepts this cycle (combinational).
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  valid tag of last stage.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  data of last stage.
- occupancy  output  CNT_W  number of valid stages (0..DEPTH).

Behaviour:
- State per stage i (0..DEPTH-1): valid v[i] and data d[i]. out_valid=v[DEPTH-1]; out_data=d[DEPTH-1].
- Load enable ld[i] = ~v[i] | go[i].
  - go[DEPTH-1] = out_ready.
  - go[i] = ld[i+1] for i<DEPTH-1.
- in_ready = ld[0] & ~flush & ~rst. This is a combinational path from out_ready through the chain; no skid register.
- On a clock edge with ld[i]=1:
  - v[i] <= source valid, where the source valid is in_valid for i=0 and v[i-1] for i>0.
  - d[i] <= source data only when the source valid is 1; otherwise d[i] holds.
- Stages with ld[i]=0 hold both v and d.
- Bubble collapsing: an invalid stage always loads, so gaps close while the output is stalled. A full pipe with out_ready=0 holds every stage and drops in_ready.
- Handshake:
  - Input beat transfers when in_valid & in_ready.
  - Output beat transfers when out_valid & out_ready.
  - Upstream must hold in_data stable while in_valid=1 and in_ready=0.
- Latency: a beat accepted at edge N appears on out_valid after edge N+DEPTH-1 if never stalled. DEPTH=1 is a single valid-tagged register.
- Throughput: 1 beat/cycle with out_ready held high.
- Simultaneous transfer into and out of a full pipe is legal: occupancy stays unchanged and every stage shifts.
- Occupancy is a registered counter, not a popcount:
  - +1 on input transfer only; -1 on output transfer only; unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Flush (rst=0, flush=1): all v<=0 and occupancy<=0. The beat offered that cycle is dropped (in_ready=0). An output transfer in the flush cycle still counts as taken if out_ready=1.
- Reset (rst=1): all v<=0, all d<=0, occupancy<=0; out_valid=0, out_data=0, in_ready=0 during reset. Reset has priority over flush. Reset mid-stream discards all beats.
- After reset/flush deassertion: in_ready=1 in the first cycle.

Test Plan:
- WIDTH=21, DEPTH=3; rst 2 cycles then in_valid=1, in_data=-1048576, out_ready=1 -> out_valid=1, out_data=-1048576 after 3rd edge; occupancy 1,2,3.
- WIDTH=32, DEPTH=4; stream 0x80000000, 0x789ABCDE, 0x0123CDEF back-to-back with out_ready=1 -> same three values on consecutive cycles from edge 4, signed display -2147483648, 2023406814, 19123695.
- DEPTH=4; out_ready=0, feed 6 beats -> in_ready falls after 4 accepted and occupancy=4. Raise out_ready -> beats 1..6 emerge in order, no duplicates or losses.
- DEPTH=4; feed beats with in_valid gaps while out_ready=0 -> gaps collapse and occupancy reaches 4 with no internal bubbles.
- Mid-stream flush with occupancy=3 -> next cycle out_valid=0, occupancy=0, in_ready=1. Beat offered in flush cycle never appears.
- WIDTH=4, DEPTH=1; in_data=4'b1000, 4'b0101, 4'b1110 each held one cycle, out_ready=1 -> out_data -8, 5, -2 one cycle later each. rst asserted mid-stream -> out_valid=0, out_data=0 next edge.
